// File: rtl/mod_counter_updown.sv
// Parametrised modulo up/down counter with clock enable, synchronous load,
// optional saturation and a combinational carry/borrow terminal-count strobe.
module mod_counter_updown #(
  parameter int unsigned     N        = 4,
  parameter longint unsigned MOD      = 64'd1 << N,
  parameter longint unsigned INIT     = 64'd0,
  parameter bit              SATURATE = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         ce_i,
  input  logic         up_i,
  input  logic         ld_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] o_o,
  output logic         cout_o
);

  localparam logic [N-1:0] MAX_C  = N'(MOD - 64'd1);
  localparam logic [N-1:0] INIT_C = N'(INIT);
  // Full-range modulus wraps through plain N-bit overflow, so no compare path.
  localparam bit FULL_RANGE = (MOD == (64'd1 << N));

  logic [N-1:0] o_q;
  logic [N-1:0] o_d;
  logic         at_top;
  logic         at_bot;
  logic         term;
  logic         load_ok;

  assign at_top  = (o_q == MAX_C);
  assign at_bot  = (o_q == '0);
  assign term    = up_i ? at_top : at_bot;
  assign load_ok = FULL_RANGE || (64'(data_i) < MOD);

  always_comb begin
    o_d = o_q;
    if (reset_i) begin
      o_d = INIT_C;
    end else if (ld_i) begin
      o_d = load_ok ? data_i : MAX_C;
    end else if (ce_i) begin
      if (term && SATURATE) begin
        o_d = o_q;
      end else if (term && !FULL_RANGE) begin
        o_d = up_i ? '0 : MAX_C;
      end else begin
        o_d = up_i ? (o_q + 1'b1) : (o_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    o_q <= o_d;
  end

  assign o_o    = o_q;
  assign cout_o = ~reset_i & ~ld_i & ce_i & term;

endmodule

// File: tb/tb_mod_counter_updown.sv
// Bench for mod_counter_updown: three configurations driven in lockstep and
// compared each cycle against a plain-arithmetic reference model.
module tb_mod_counter_updown;

  localparam int NDUT = 3;
  localparam int MODS [NDUT] = '{16, 10, 10};
  localparam int INITS[NDUT] = '{0, 0, 3};
  localparam int SATS [NDUT] = '{0, 0, 1};

  logic       clk;
  logic       reset;
  logic       ce;
  logic       up;
  logic       ld;
  logic [3:0] data;
  logic [3:0] o_w   [NDUT];
  logic       cout_w[NDUT];

  int model_o[NDUT];
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_counter_updown #(.N(4), .MOD(64'd16), .INIT(64'd0), .SATURATE(1'b0)) u_wrap16 (
    .clk_i(clk), .reset_i(reset), .ce_i(ce), .up_i(up), .ld_i(ld), .data_i(data),
    .o_o(o_w[0]), .cout_o(cout_w[0]));

  mod_counter_updown #(.N(4), .MOD(64'd10), .INIT(64'd0), .SATURATE(1'b0)) u_wrap10 (
    .clk_i(clk), .reset_i(reset), .ce_i(ce), .up_i(up), .ld_i(ld), .data_i(data),
    .o_o(o_w[1]), .cout_o(cout_w[1]));

  mod_counter_updown #(.N(4), .MOD(64'd10), .INIT(64'd3), .SATURATE(1'b1)) u_sat10 (
    .clk_i(clk), .reset_i(reset), .ce_i(ce), .up_i(up), .ld_i(ld), .data_i(data),
    .o_o(o_w[2]), .cout_o(cout_w[2]));

  // Reference next value from the behavioural rules, using plain arithmetic.
  function automatic int ref_next(int k, int o, bit r, bit l, bit c, bit u, int d);
    int m;
    m = MODS[k];
    if (r) return INITS[k];
    if (l) return (d < m) ? d : m - 1;
    if (!c) return o;
    if (u) begin
      if (SATS[k] != 0) return (o + 1 > m - 1) ? m - 1 : o + 1;
      return (o + 1) % m;
    end
    if (SATS[k] != 0) return (o - 1 < 0) ? 0 : o - 1;
    return (o + m - 1) % m;
  endfunction

  function automatic bit ref_cout(int k, int o, bit r, bit l, bit c, bit u);
    if (r || l || !c) return 1'b0;
    return u ? (o == MODS[k] - 1) : (o == 0);
  endfunction

  // One clock: apply inputs, check the strobe before the edge, check O after it.
  task automatic cyc(input bit r, input bit l, input bit c, input bit u, input int d,
                     input string tag);
    bit exp_c;
    int exp_o;
    @(negedge clk);
    reset = r; ld = l; ce = c; up = u; data = 4'(d);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      exp_c = ref_cout(k, model_o[k], r, l, c, u);
      n_checks++;
      assert (cout_w[k] === exp_c) else begin
        n_fail++;
        $error("FAIL %s cout dut%0d: observed %0b expected %0b", tag, k, cout_w[k], exp_c);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      exp_o = ref_next(k, model_o[k], r, l, c, u, d);
      model_o[k] = exp_o;
      n_checks++;
      assert (o_w[k] === 4'(exp_o)) else begin
        n_fail++;
        $error("FAIL %s o dut%0d: observed %0d expected %0d", tag, k, o_w[k], exp_o);
      end
    end
    $display("step %-6s rst=%0b ld=%0b ce=%0b up=%0b d=%0d -> o=%0d/%0d/%0d",
             tag, r, l, c, u, d, o_w[0], o_w[1], o_w[2]);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; ld = 1'b0; ce = 1'b0; up = 1'b1; data = '0;
    for (int k = 0; k < NDUT; k++) model_o[k] = 0;

    cyc(1, 0, 1, 1, 0, "rst");
    cyc(1, 1, 1, 0, 9, "rst");

    // Count up through the full range and past the wrap.
    cyc(1, 0, 0, 1, 0, "t1rst");
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, 0, "t1up");

    // Count down from zero across the borrow.
    cyc(0, 1, 0, 0, 0, "t2ld");
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 0, "t2dn");

    // Loads in range and out of range, with CE high.
    cyc(0, 1, 1, 1, 7, "t3ld");
    cyc(0, 1, 1, 1, 12, "t3clmp");

    // Climb into the top terminal value, then reverse.
    cyc(0, 1, 0, 1, 8, "t4ld");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, "t4up");
    cyc(0, 0, 1, 0, 0, "t4rev");

    // Reset beats a simultaneous load and count.
    cyc(0, 1, 0, 1, 5, "t5ld");
    cyc(1, 1, 1, 1, 3, "t5rst");

    // CE gating with alternating direction.
    cyc(0, 1, 0, 1, 0, "t6ld");
    cyc(0, 0, 1, 1, 0, "t6ce");
    cyc(0, 0, 0, 0, 0, "t6hold");
    cyc(0, 0, 0, 1, 0, "t6hold");
    cyc(0, 0, 1, 0, 0, "t6ce");
    cyc(0, 0, 1, 0, 0, "t6ce");

    // Saturating hold at the bottom end.
    cyc(0, 1, 0, 0, 1, "satld");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, "satdn");

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(49) == 0), ($urandom_range(9) == 0), ($urandom_range(3) != 0),
          1'($urandom), int'($urandom_range(15)), "rand");
      for (int k = 1; k < NDUT; k++) begin
        n_checks++;
        assert (o_w[k] < 4'd10) else begin
          n_fail++;
          $error("FAIL range dut%0d: observed %0d expected below 10", k, o_w[k]);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
